// File: rtl/x7seg_scan_n_if.sv
// Control and display bundle for the multiplexed 7-segment driver.
// The producer side drives value/mode/attributes; the driver returns status and pin levels.
interface x7seg_scan_n_if #(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
);
  logic [BIN_W-1:0]   x;
  logic               load;
  logic               dec_mode;
  logic               blank_lz;
  logic [NDIGITS-1:0] dp;
  logic [NDIGITS-1:0] blink;
  logic               busy;
  logic               ovf;
  logic [6:0]         g_to_a;
  logic               dp_n;
  logic [NDIGITS-1:0] an;

  modport master (
    output x, load, dec_mode, blank_lz, dp, blink,
    input  busy, ovf, g_to_a, dp_n, an
  );

  modport slave (
    input  x, load, dec_mode, blank_lz, dp, blink,
    output busy, ovf, g_to_a, dp_n, an
  );
endinterface

// File: rtl/x7seg_scan_n.sv
// N-digit multiplexed common-anode 7-segment driver with hex/decimal display,
// sequential shift-add-3 BCD conversion, leading-zero blanking, blink and overflow dashes.
module x7seg_scan_n #(
  parameter int NDIGITS   = 4,
  parameter int BIN_W     = 14,
  parameter int DIV_BITS  = 18,
  parameter int BLINK_BIT = 24
) (
  input  logic           clk,
  input  logic           clr,
  x7seg_scan_n_if.slave  bus
);

  localparam int DW    = 4 * NDIGITS;
  localparam int IDX_W = $clog2(NDIGITS);
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [BIN_W-1:0]   sh;
  logic [DW-1:0]      bcd;
  logic [DW-1:0]      adj;
  logic [DW-1:0]      bcd_next;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_work;
  logic               ovf_next;
  logic               load_ok;
  logic               conv_last;

  logic [DW-1:0]      disp;
  logic               ovf_r;

  logic [DIV_BITS-1:0] presc;
  logic [BLINK_BIT:0]  blink_cnt;
  logic [IDX_W-1:0]    idx;

  logic [NDIGITS-1:0] upper_zero;
  logic               all_zero;
  logic [3:0]         nib;
  logic               dp_sel;
  logic               blink_sel;
  logic               uz_sel;
  logic               dark;
  logic [NDIGITS-1:0] an_next;
  logic [6:0]         seg_next;
  logic               dp_n_next;

  logic [NDIGITS-1:0] an_r;
  logic [6:0]         seg_r;
  logic               dp_n_r;

  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'h0: seg_font = 7'b1000000;
      4'h1: seg_font = 7'b1111001;
      4'h2: seg_font = 7'b0100100;
      4'h3: seg_font = 7'b0110000;
      4'h4: seg_font = 7'b0011001;
      4'h5: seg_font = 7'b0010010;
      4'h6: seg_font = 7'b0000010;
      4'h7: seg_font = 7'b1111000;
      4'h8: seg_font = 7'b0000000;
      4'h9: seg_font = 7'b0010000;
      4'hA: seg_font = 7'b0001000;
      4'hB: seg_font = 7'b0000011;
      4'hC: seg_font = 7'b1000110;
      4'hD: seg_font = 7'b0100001;
      4'hE: seg_font = 7'b0000110;
      default: seg_font = 7'b0001110;
    endcase
  endfunction

  // A load is only honoured while idle, so an in-flight conversion can never be disturbed.
  assign load_ok   = bus.load && (state == S_IDLE);
  assign conv_last = (state == S_CONV) && (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (load_ok && bus.dec_mode) state_next = S_CONV;
      S_CONV: if (conv_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One double-dabble step; a 1 leaving the top nibble means the value needs more digits.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = {adj[DW-2:0], sh[BIN_W-1]};
    ovf_next = ovf_work | adj[DW-1];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
      disp     <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (load_ok && !bus.dec_mode) begin
        disp  <= DW'(bus.x);
        ovf_r <= 1'b0;
      end
      if (load_ok && bus.dec_mode) begin
        sh       <= bus.x;
        bcd      <= '0;
        cnt      <= '0;
        ovf_work <= 1'b0;
      end else if (state == S_CONV) begin
        sh       <= sh << 1;
        bcd      <= bcd_next;
        cnt      <= cnt + CNT_W'(1);
        ovf_work <= ovf_next;
        if (conv_last) begin
          disp  <= bcd_next;
          ovf_r <= ovf_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc     <= '0;
      blink_cnt <= '0;
      idx       <= '0;
    end else begin
      presc     <= presc + DIV_BITS'(1);
      blink_cnt <= blink_cnt + (BLINK_BIT + 1)'(1);
      if (&presc) begin
        idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // upper_zero[i] is set when digit i and everything above it is zero.
  always_comb begin
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero && (disp[4*i +: 4] == 4'd0);
      upper_zero[i] = all_zero;
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blink_sel = 1'b0;
    uz_sel    = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp[4*i +: 4];
        dp_sel    = bus.dp[i];
        blink_sel = bus.blink[i];
        uz_sel    = upper_zero[i];
      end
    end

    dark = (bus.blank_lz && !ovf_r && (idx != '0) && uz_sel) ||
           (blink_sel && blink_cnt[BLINK_BIT]);

    an_next = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!dark && (idx == IDX_W'(i))) an_next[i] = 1'b0;
    end

    if (dark) begin
      seg_next = 7'h7F;
    end else if (ovf_r) begin
      seg_next = 7'b0111111;
    end else begin
      seg_next = seg_font(nib);
    end
    dp_n_next = dark ? 1'b1 : ~dp_sel;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an_r   <= '1;
      seg_r  <= 7'h7F;
      dp_n_r <= 1'b1;
    end else begin
      an_r   <= an_next;
      seg_r  <= seg_next;
      dp_n_r <= dp_n_next;
    end
  end

  assign bus.an     = an_r;
  assign bus.g_to_a = seg_r;
  assign bus.dp_n   = dp_n_r;
  assign bus.busy   = (state == S_CONV);
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_x7seg_scan_n.sv
// Randomised scoreboard bench for x7seg_scan_n: loads queue their expected display,
// a reference model advances per clock and a negedge monitor compares every output.
module tb_x7seg_scan_n;
  localparam int ND  = 4;
  localparam int BW  = 14;
  localparam int DIV = 2;
  localparam int BB  = 6;

  logic clk = 1'b0;
  logic clr;

  x7seg_scan_n_if #(.NDIGITS(ND), .BIN_W(BW)) bus ();

  x7seg_scan_n #(
    .NDIGITS(ND), .BIN_W(BW), .DIV_BITS(DIV), .BLINK_BIT(BB)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int   due;
    int   val;
    logic dec;
  } entry_t;

  entry_t        exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_n     = 0;
  int            m_dig[ND];
  logic          m_ovf;
  logic [ND-1:0] exp_an;
  logic [6:0]    exp_seg;
  logic          exp_dpn;
  logic          exp_busy;
  logic          exp_ovf;

  function automatic logic [6:0] font_of(input int d);
    case (d)
      0: font_of = 7'b1000000;  1: font_of = 7'b1111001;
      2: font_of = 7'b0100100;  3: font_of = 7'b0110000;
      4: font_of = 7'b0011001;  5: font_of = 7'b0010010;
      6: font_of = 7'b0000010;  7: font_of = 7'b1111000;
      8: font_of = 7'b0000000;  9: font_of = 7'b0010000;
      10: font_of = 7'b0001000; 11: font_of = 7'b0000011;
      12: font_of = 7'b1000110; 13: font_of = 7'b0100001;
      14: font_of = 7'b0000110; default: font_of = 7'b0001110;
    endcase
  endfunction

  function automatic int p10(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s edge=%0d got=%0h want=%0h", name, m_n, got, want);
    end
  endtask

  // Reference model: what the pins must show after the edge, from the digits as a person would read them.
  initial begin : model
    int     i;
    int     sig;
    logic   dark;
    entry_t e;
    m_ovf    = 1'b0;
    exp_an   = '1;
    exp_seg  = 7'h7F;
    exp_dpn  = 1'b1;
    exp_busy = 1'b0;
    exp_ovf  = 1'b0;
    for (int j = 0; j < ND; j++) m_dig[j] = 0;
    forever begin
      @(posedge clk);
      if (clr) begin
        m_n   = 0;
        m_ovf = 1'b0;
        for (int j = 0; j < ND; j++) m_dig[j] = 0;
        exp_q.delete();
        exp_an   = '1;
        exp_seg  = 7'h7F;
        exp_dpn  = 1'b1;
        exp_busy = 1'b0;
        exp_ovf  = 1'b0;
      end else begin
        i   = (m_n / (1 << DIV)) % ND;
        sig = 1;
        for (int j = 0; j < ND; j++) if (m_dig[j] != 0) sig = j + 1;
        dark = (bus.blank_lz && !m_ovf && (i >= sig)) ||
               (bus.blink[i] && (((m_n >> BB) % 2) == 1));
        exp_an = '1;
        if (!dark) exp_an[i] = 1'b0;
        exp_seg = dark ? 7'h7F : (m_ovf ? 7'b0111111 : font_of(m_dig[i]));
        exp_dpn = dark ? 1'b1 : !bus.dp[i];
        m_n++;
        if (exp_q.size() > 0 && exp_q[0].due == m_n) begin
          e = exp_q.pop_front();
          if (e.dec) begin
            m_ovf = (e.val >= p10(ND));
            for (int j = 0; j < ND; j++) m_dig[j] = (e.val / p10(j)) % 10;
          end else begin
            m_ovf = 1'b0;
            for (int j = 0; j < ND; j++) m_dig[j] = (e.val >> (4 * j)) % 16;
          end
        end
        exp_busy = (exp_q.size() > 0) && exp_q[0].dec && (m_n >= exp_q[0].due - BW);
        exp_ovf  = m_ovf;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (clr) begin
        checkOutput("rst_an",   32'(bus.an), 32'({ND{1'b1}}));
        checkOutput("rst_seg",  32'(bus.g_to_a), 32'h7F);
        checkOutput("rst_dp_n", 32'(bus.dp_n), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ovf",  32'(bus.ovf), 32'd0);
      end else begin
        checkOutput("an",   32'(bus.an), 32'(exp_an));
        checkOutput("seg",  32'(bus.g_to_a), 32'(exp_seg));
        checkOutput("dp_n", 32'(bus.dp_n), 32'(exp_dpn));
        checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
        checkOutput("ovf",  32'(bus.ovf), 32'(exp_ovf));
      end
    end
  end

  // Called just after a rising edge; the load is sampled on the following edge.
  task automatic applyStimulus(input logic [BW-1:0] xv, input logic dec, input bit accepted);
    bus.x        = xv;
    bus.dec_mode = dec;
    bus.load     = 1'b1;
    if (accepted) exp_q.push_back('{due: dec ? m_n + 1 + BW : m_n + 1, val: int'(xv), dec: dec});
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("[TB] FAIL wait_idle pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : stimulus
    clr          = 1'b1;
    bus.x        = '0;
    bus.load     = 1'b0;
    bus.dec_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.dp       = '0;
    bus.blink    = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    applyStimulus(BW'(16'hBEEF), 1'b0, 1'b1);
    runCycles(20);
    bus.dp = 4'b0101;
    runCycles(16);
    applyStimulus(BW'(9999), 1'b1, 1'b1);
    waitIdle();
    runCycles(16);
    applyStimulus(BW'(12345), 1'b1, 1'b1);
    waitIdle();
    runCycles(16);
    bus.blank_lz = 1'b1;
    runCycles(16);
    applyStimulus(BW'(16'h0042), 1'b0, 1'b1);
    runCycles(20);
    applyStimulus(BW'(0), 1'b0, 1'b1);
    runCycles(20);
    bus.blink = 4'b1010;
    runCycles(140);
    bus.blink = '0;

    for (int it = 0; it < 30; it++) begin
      bus.blank_lz = 1'($urandom);
      bus.dp       = ND'($urandom);
      bus.blink    = ND'($urandom);
      if ($urandom % 2 == 1) begin
        applyStimulus(BW'($urandom), 1'b1, 1'b1);
        if ($urandom % 2 == 1) begin
          runCycles($urandom_range(1, 10));
          applyStimulus(BW'($urandom), 1'($urandom), 1'b0);
        end
      end else begin
        applyStimulus(BW'($urandom), 1'b0, 1'b1);
      end
      waitIdle();
      runCycles($urandom_range(8, 60));
      bus.dp = ND'($urandom);
      runCycles($urandom_range(4, 80));
    end

    // Abort a conversion: ignored second load, then reset part-way through.
    bus.blank_lz = 1'b0;
    bus.blink    = '0;
    bus.dp       = '0;
    applyStimulus(BW'(1234), 1'b1, 1'b1);
    runCycles(3);
    applyStimulus(BW'(4321), 1'b0, 1'b0);
    clr = 1'b1;
    runCycles(2);
    clr = 1'b0;
    runCycles(20);
    bus.blank_lz = 1'b1;
    runCycles(20);
    applyStimulus(BW'(9999), 1'b1, 1'b1);
    waitIdle();
    runCycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
